// File: rtl/tester_ctrl.sv
// tester_ctrl: test-sequencing controller for the FPGA tester.
// Consumes one-cycle key pulses: the switch key cycles the active test mode,
// the reset key starts a run (or aborts one in progress). A run issues a
// one-cycle start strobe, is supervised by a timeout counter, and ends in a
// latched PASS/FAIL verdict that holds until the next key pulse.
//
// Key handshake: in_key_switch / in_key_reset are single-cycle pulses that
// are consumed on the clock edge where they are high; no acknowledge exists.
// in_test_done / in_test_pass form a one-cycle result beat from the engine
// and are only sampled while the controller is in RUN.
module tester_ctrl #(
    parameter int NUM_MODES = 4,
    parameter int TIMEOUT   = 1000,
    localparam int MODE_W   = ($clog2(NUM_MODES) > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_key_switch,
    input  logic              in_key_reset,
    input  logic              in_test_done,
    input  logic              in_test_pass,
    output logic [MODE_W-1:0] o_mode,
    output logic              o_test_start,
    output logic              o_test_run,
    output logic              o_pass,
    output logic              o_fail,
    output logic              o_timeout
);

    // Counter holds 0..TIMEOUT, so it can never wrap inside a run.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_PASS  = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [MODE_W-1:0] r_mode;
    logic [MODE_W-1:0] w_mode_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_timeout;
    logic              w_timeout_next;
    logic              w_cnt_last;

    assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT - 1));

    // State, mode, counter and timeout flag registers.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state   <= S_IDLE;
            r_mode    <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_mode    <= w_mode_next;
            r_cnt     <= w_cnt_next;
            r_timeout <= w_timeout_next;
        end
    end

    // Next-state logic: key handling in resting states, supervision in RUN.
    always_comb begin
        w_state_next   = r_state;
        w_mode_next    = r_mode;
        w_cnt_next     = r_cnt;
        w_timeout_next = r_timeout;
        case (r_state)
            S_IDLE, S_PASS, S_FAIL: begin
                // Switch wins over reset when both arrive together; the
                // reset pulse is simply dropped.
                if (in_key_switch) begin
                    w_mode_next    = (r_mode == MODE_W'(NUM_MODES - 1))
                                     ? '0 : r_mode + MODE_W'(1);
                    w_state_next   = S_IDLE;
                    w_timeout_next = 1'b0;
                end else if (in_key_reset) begin
                    w_state_next   = S_START;
                    w_timeout_next = 1'b0;
                end
            end
            S_START: begin
                w_cnt_next   = '0;
                w_state_next = S_RUN;
            end
            S_RUN: begin
                w_cnt_next = r_cnt + CNT_W'(1);
                // Priority: operator abort, then engine result, then timeout.
                if (in_key_reset) begin
                    w_state_next = S_IDLE;
                end else if (in_test_done) begin
                    w_state_next = in_test_pass ? S_PASS : S_FAIL;
                end else if (w_cnt_last) begin
                    w_state_next   = S_FAIL;
                    w_timeout_next = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_mode       = r_mode;
    assign o_test_start = (r_state == S_START);
    assign o_test_run   = (r_state == S_RUN);
    assign o_pass       = (r_state == S_PASS);
    assign o_fail       = (r_state == S_FAIL);
    assign o_timeout    = r_timeout;

endmodule
